// File: rtl/ahb_lite_decoder_mux_if.sv
// Bus bundle between one AHB-Lite master, the decoder/mux and NUM_SLV slaves.
// The slave modport is the interconnect's view; master is the surrounding environment's view.
interface ahb_lite_decoder_mux_if #(
    parameter int unsigned NUM_SLV = 3
);
    logic [31:0]          M_HADDR;
    logic [1:0]           M_HTRANS;
    logic [31:0]          M_HRDATA;
    logic [1:0]           M_HRESP;
    logic                 M_HREADY;
    logic [NUM_SLV-1:0]   S_HSEL;
    logic                 S_HREADY;
    logic [32*NUM_SLV-1:0] S_HRDATA;
    logic [2*NUM_SLV-1:0] S_HRESP;
    logic [NUM_SLV-1:0]   S_HREADYout;
    logic                 TO_FLAG;
    logic [NUM_SLV-1:0]   DEAD_MASK;

    modport slave (
        input  M_HADDR, M_HTRANS, S_HRDATA, S_HRESP, S_HREADYout,
        output M_HRDATA, M_HRESP, M_HREADY, S_HSEL, S_HREADY, TO_FLAG, DEAD_MASK
    );

    modport master (
        output M_HADDR, M_HTRANS, S_HRDATA, S_HRESP, S_HREADYout,
        input  M_HRDATA, M_HRESP, M_HREADY, S_HSEL, S_HREADY, TO_FLAG, DEAD_MASK
    );
endinterface

// File: rtl/ahb_lite_decoder_mux.sv
// AHB-Lite 1:N interconnect: address decoder, data-phase response mux, built-in default slave
// and a per-data-phase HREADY watchdog that fails and permanently masks a hung slave.
module ahb_lite_decoder_mux #(
    parameter int unsigned               NUM_SLV   = 3,
    parameter logic [32*NUM_SLV-1:0]     ADDR_BASE = {32'h7A00_0000, 32'h7900_0000, 32'h7800_0000},
    parameter logic [32*NUM_SLV-1:0]     ADDR_MASK = {3{32'hFF00_0000}},
    parameter int unsigned               TIMEOUT   = 16
) (
    input logic                    HCLK,
    input logic                    HRESET,
    ahb_lite_decoder_mux_if.slave  bus
);

    localparam int unsigned SelW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {StIdle, StSlv, StErr1, StErr2} state_e;

    state_e              state_q;
    logic [SelW-1:0]     dp_sel_q;
    logic [CntW-1:0]     cnt_q;
    logic [NUM_SLV-1:0]  dead_q;
    logic                to_flag_q;

    logic [NUM_SLV-1:0]  match;
    logic [NUM_SLV-1:0]  hsel;
    logic                hit;
    logic [SelW-1:0]     win;

    logic                sel_ready;
    logic [1:0]          sel_resp;
    logic [31:0]         sel_data;
    logic                m_hready;
    logic [1:0]          m_hresp;
    logic [31:0]         m_hrdata;
    logic                timeout_hit;

    // Only HTRANS[1] distinguishes active transfers from IDLE/BUSY.
    logic unused_htrans0;
    assign unused_htrans0 = bus.M_HTRANS[0];

    // Descending scan so the lowest matching index is the one left in win.
    always_comb begin
        match = '0;
        hit   = 1'b0;
        win   = '0;
        hsel  = '0;
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            match[i] = ((bus.M_HADDR & ADDR_MASK[32*i +: 32]) == ADDR_BASE[32*i +: 32])
                       && !dead_q[i];
        end
        for (int i = int'(NUM_SLV) - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit = 1'b1;
                win = SelW'(i);
            end
        end
        if (hit && !HRESET) begin
            hsel[win] = 1'b1;
        end
    end

    always_comb begin
        sel_ready = bus.S_HREADYout[dp_sel_q];
        sel_resp  = bus.S_HRESP[2*dp_sel_q +: 2];
        sel_data  = bus.S_HRDATA[32*dp_sel_q +: 32];
        m_hready  = 1'b1;
        m_hresp   = 2'b00;
        m_hrdata  = '0;
        case (state_q)
            StSlv: begin
                m_hready = sel_ready;
                m_hresp  = sel_resp;
                m_hrdata = sel_data;
            end
            StErr1: begin
                m_hready = 1'b0;
                m_hresp  = 2'b01;
            end
            StErr2: begin
                m_hready = 1'b1;
                m_hresp  = 2'b01;
            end
            default: ;
        endcase
    end

    // Fires on the last permitted wait cycle, so the slave gets exactly TIMEOUT waits.
    assign timeout_hit = (TIMEOUT != 0) && (state_q == StSlv) && !sel_ready
                         && (int'(cnt_q) == int'(TIMEOUT) - 1);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= StIdle;
            dp_sel_q  <= '0;
            cnt_q     <= '0;
            dead_q    <= '0;
            to_flag_q <= 1'b0;
        end else if (m_hready) begin
            cnt_q <= '0;
            if (!bus.M_HTRANS[1]) begin
                state_q <= StIdle;
            end else if (hit) begin
                state_q  <= StSlv;
                dp_sel_q <= win;
            end else begin
                state_q <= StErr1;
            end
        end else begin
            case (state_q)
                StSlv: begin
                    if (timeout_hit) begin
                        state_q          <= StErr1;
                        dead_q[dp_sel_q] <= 1'b1;
                        to_flag_q        <= 1'b1;
                    end else if (cnt_q != {CntW{1'b1}}) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StErr1:  state_q <= StErr2;
                default: ;
            endcase
        end
    end

    assign bus.M_HREADY  = m_hready;
    assign bus.M_HRESP   = m_hresp;
    assign bus.M_HRDATA  = m_hrdata;
    assign bus.S_HREADY  = m_hready;
    assign bus.S_HSEL    = hsel;
    assign bus.TO_FLAG   = to_flag_q;
    assign bus.DEAD_MASK = dead_q;

endmodule
